// File: rtl/alu_operand_pkg.sv
// alu_operand_pkg: shared select codes, default widths and stage state type for the ALU operand stage
package alu_operand_pkg;
    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int SHAMT_W_DEF    = 5;
    localparam int LUI_SHIFT_DEF  = 16;

    localparam logic [1:0] SRC_A_RS  = 2'b00;
    localparam logic [1:0] SRC_A_RT  = 2'b01;
    localparam logic [1:0] SRC_A_IMM = 2'b10;

    localparam logic [2:0] SRC_B_RT    = 3'b000;
    localparam logic [2:0] SRC_B_RS    = 3'b001;
    localparam logic [2:0] SRC_B_IMM   = 3'b010;
    localparam logic [2:0] SRC_B_SHAMT = 3'b011;
    localparam logic [2:0] SRC_B_LUI   = 3'b100;

    typedef enum logic {ST_EMPTY, ST_FULL} stage_state_e;
endpackage

// File: rtl/operand_bypass.sv
// operand_bypass: combinational EX/MEM (and, with ALU_OPERAND_MEMWB_FWD_EN, MEM/WB) forwarding for one source operand
module operand_bypass #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0]     rd_data,
    input  logic                  exmem_wr_en,
    input  logic [REG_ADDR_W-1:0] exmem_wr_addr,
    input  logic [DATA_W-1:0]     exmem_wr_data,
    input  logic                  memwb_wr_en,
    input  logic [REG_ADDR_W-1:0] memwb_wr_addr,
    input  logic [DATA_W-1:0]     memwb_wr_data,
    output logic [DATA_W-1:0]     fwd_data
);
    logic nonzero;
    assign nonzero = rd_addr != '0;
`ifdef ALU_OPERAND_MEMWB_FWD_EN
    // Youngest producer wins: EX/MEM before MEM/WB, register zero never forwarded
    always_comb begin
        fwd_data = (nonzero && exmem_wr_en && exmem_wr_addr == rd_addr) ? exmem_wr_data :
                   (nonzero && memwb_wr_en && memwb_wr_addr == rd_addr) ? memwb_wr_data : rd_data;
    end
`else
    logic unused_memwb;
    assign unused_memwb = ^{memwb_wr_en, memwb_wr_addr, memwb_wr_data};
    // Only EX/MEM forwarding exists; register zero never forwarded
    always_comb begin
        fwd_data = (nonzero && exmem_wr_en && exmem_wr_addr == rd_addr) ? exmem_wr_data : rd_data;
    end
`endif
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: registered ID/EX operand select with forwarding, valid/ready, stall and flush (MEM/WB forwarding via ALU_OPERAND_MEMWB_FWD_EN)
module alu_operand_stage import alu_operand_pkg::*; #(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int SHAMT_W    = SHAMT_W_DEF,
    parameter int LUI_SHIFT  = LUI_SHIFT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    input  logic [DATA_W-1:0]     rs_data,
    input  logic [DATA_W-1:0]     rt_data,
    input  logic [DATA_W-1:0]     ext_imm,
    input  logic [SHAMT_W-1:0]    shamt,
    input  logic [1:0]            alu_src_a,
    input  logic [2:0]            alu_src_b,
    input  logic                  exmem_wr_en,
    input  logic [REG_ADDR_W-1:0] exmem_wr_addr,
    input  logic [DATA_W-1:0]     exmem_wr_data,
    input  logic                  memwb_wr_en,
    input  logic [REG_ADDR_W-1:0] memwb_wr_addr,
    input  logic [DATA_W-1:0]     memwb_wr_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     in1,
    output logic [DATA_W-1:0]     in2,
    output logic                  sel_err
);
    stage_state_e      state_q, state_d;
    logic [DATA_W-1:0] in1_q, in1_d, in2_q, in2_d;
    logic              sel_err_q, sel_err_d;
    logic [DATA_W-1:0] fwd_rs, fwd_rt, a_sel, b_sel;
    logic              a_bad, b_bad, load;

    operand_bypass #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_rs_bypass (
        .rd_addr(rs_addr), .rd_data(rs_data),
        .exmem_wr_en(exmem_wr_en), .exmem_wr_addr(exmem_wr_addr), .exmem_wr_data(exmem_wr_data),
        .memwb_wr_en(memwb_wr_en), .memwb_wr_addr(memwb_wr_addr), .memwb_wr_data(memwb_wr_data),
        .fwd_data(fwd_rs)
    );

    operand_bypass #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_rt_bypass (
        .rd_addr(rt_addr), .rd_data(rt_data),
        .exmem_wr_en(exmem_wr_en), .exmem_wr_addr(exmem_wr_addr), .exmem_wr_data(exmem_wr_data),
        .memwb_wr_en(memwb_wr_en), .memwb_wr_addr(memwb_wr_addr), .memwb_wr_data(memwb_wr_data),
        .fwd_data(fwd_rt)
    );

    assign in_ready  = state_q == ST_EMPTY || out_ready;
    assign out_valid = state_q == ST_FULL;
    assign in1       = in1_q;
    assign in2       = in2_q;
    assign sel_err   = sel_err_q;

    // Operand muxes; undefined codes give zero and flag an error
    always_comb begin
        a_bad = alu_src_a == 2'b11;
        a_sel = alu_src_a == SRC_A_RS  ? fwd_rs :
                alu_src_a == SRC_A_RT  ? fwd_rt :
                alu_src_a == SRC_A_IMM ? ext_imm : '0;
        b_bad = alu_src_b > SRC_B_LUI;
        b_sel = alu_src_b == SRC_B_RT    ? fwd_rt :
                alu_src_b == SRC_B_RS    ? fwd_rs :
                alu_src_b == SRC_B_IMM   ? ext_imm :
                alu_src_b == SRC_B_SHAMT ? DATA_W'(shamt) :
                alu_src_b == SRC_B_LUI   ? DATA_W'(LUI_SHIFT) : '0;
    end

    // Next state: flush empties the stage and beats any load; a stalled FULL stage holds
    always_comb begin
        load      = in_valid && in_ready && !flush;
        state_d   = flush ? ST_EMPTY : load ? ST_FULL : out_ready ? ST_EMPTY : state_q;
        in1_d     = load ? a_sel : in1_q;
        in2_d     = load ? b_sel : in2_q;
        sel_err_d = sel_err_q || (load && (a_bad || b_bad));
    end

    // Stage registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            in1_q     <= '0;
            in2_q     <= '0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            in1_q     <= in1_d;
            in2_q     <= in2_d;
            sel_err_q <= sel_err_d;
        end
    end
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Registered successor to the single-cycle ALU operand mux, used as the ID/EX operand-select stage of the pipelined CPU.
- Resolves the rs/rt operands through EX/MEM (and optionally MEM/WB) forwarding.
- Selects ALU inputs A and B from the register, immediate, shift-amount and constant sources.
- Registers the result behind a valid/ready handshake with stall and flush.
- Undefined select codes drive zero and raise a sticky error; they never hold a stale value.

Parameters:
- DATA_W, 32, operand/data width.
- REG_ADDR_W, 5, register-file address width.
- SHAMT_W, 5, shift-amount width; must be <= DATA_W.
- LUI_SHIFT, 16, constant driven on B for select 3'b100.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode stage presents an operation.
- in_ready  out  1  stage can accept this cycle.
- rs_addr, rt_addr  in  REG_ADDR_W  source register numbers.
- rs_data, rt_data  in  DATA_W  register-file read data.
- ext_imm  in  DATA_W  extended immediate.
- shamt  in  SHAMT_W  shift amount.
- alu_src_a  in  2  A select.
- alu_src_b  in  3  B select.
- exmem_wr_en  in  1  EX/MEM will write a register.
- exmem_wr_addr  in  REG_ADDR_W  EX/MEM destination.
- exmem_wr_data  in  DATA_W  EX/MEM result.
- memwb_wr_en  in  1  MEM/WB will write a register.
- memwb_wr_addr  in  REG_ADDR_W  MEM/WB destination.
- memwb_wr_data  in  DATA_W  MEM/WB result.
- flush  in  1  squash the held and incoming operation.
- out_valid  out  1  in1/in2 are valid.
- out_ready  in  1  ALU consumes this cycle.
- in1, in2  out  DATA_W  registered ALU operands.
- sel_err  out  1  sticky: an undefined select code was accepted.

Behaviour:
- Reset (asynchronous): out_valid=0, in1=0, in2=0, sel_err=0. Reset asserted mid-transfer discards the held operation.
- State machine has two states: EMPTY (out_valid=0) and FULL (out_valid=1).
- in_ready = !out_valid || out_ready (combinational, no bubble on back-to-back transfers).
- Load condition: in_valid && in_ready && !flush. On load, in1/in2 register the selected values and the state becomes FULL.
- FULL with out_ready=1 and no load: go to EMPTY. in1/in2 keep their last values; do not care.
- FULL with out_ready=0: in1, in2 and out_valid hold stable.
- flush=1: next state is EMPTY regardless of in_valid/out_ready; the incoming operation is dropped. Flush has priority over load.
- Forwarding, per operand (rs and rt independently), combinational before selection:
  - Address 0 is never forwarded; register value used.
  - Else if exmem_wr_en and exmem_wr_addr matches: exmem_wr_data.
  - Else if MEM/WB forwarding is enabled, memwb_wr_en is high and memwb_wr_addr matches: memwb_wr_data.
  - Else the register-file data.
  - EX/MEM wins when both paths match.
- A select: 00 fwd_rs, 01 fwd_rt, 10 ext_imm, 11 zero and error.
- B select: 000 fwd_rt, 001 fwd_rs, 010 ext_imm, 011 shamt zero-extended to DATA_W, 100 LUI_SHIFT, 101/110/111 zero and error.
- sel_err sets only on a load with an undefined code; it clears only on reset.

Optional Feature:
- Macro: ALU_OPERAND_MEMWB_FWD_EN.
- Defined: the MEM/WB forwarding path is active as described.
- Undefined: only EX/MEM forwarding exists; the memwb_* ports remain present but are ignored, and no logic is generated for them.

Decomposition:
- Package alu_operand_pkg holds:
  - localparams for the alu_src_a codes (SRC_A_RS, SRC_A_RT, SRC_A_IMM);
  - localparams for the alu_src_b codes (SRC_B_RT, SRC_B_RS, SRC_B_IMM, SRC_B_SHAMT, SRC_B_LUI);
  - the default widths.
- One sub-module, operand_bypass: combinational forwarding for a single operand (address, register data, both write ports). Instantiated twice, for rs and rt.

Test Plan:
- Basic selection: after reset, rs_data=5, rt_data=7, alu_src_a=00, alu_src_b=000, in_valid=1, out_ready=1 -> next cycle in1=5, in2=7, out_valid=1, sel_err=0.
- EX/MEM forwarding: rs_addr=3, exmem_wr_en=1, exmem_wr_addr=3, exmem_wr_data=0xAA, memwb matching with 0xBB -> in1=0xAA.
- Register zero: rs_addr=0 with exmem forwarding to address 0 -> in1=rs_data.
- MEM/WB path: memwb-only match with 0xBB -> in1=0xBB with the macro defined; in1=rs_data without it.
- Stall and flush: out_ready=0 for 3 cycles -> in1/in2/out_valid stable and in_ready=0. Then flush=1 with in_valid=1 -> next cycle out_valid=0 and the new data is not loaded.
- Constants and undefined codes: alu_src_b=011, shamt=31 -> in2=31. alu_src_b=100 -> in2=16. alu_src_b=110 -> in2=0 and sel_err=1, which stays set until rst.
- Async reset: asserting rst mid-stall -> out_valid, in1, in2 and sel_err go to 0 immediately.
